// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit: opcode and state encodings,
// default latencies, and a helper that classifies multi-cycle operations.
package mdu_ctrl_pkg;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6,
    MDU_MF    = 3'd7
  } mdu_op_e;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

  localparam int MDU_MULT_LAT = 5;
  localparam int MDU_DIV_LAT  = 10;

  // True for the ops that occupy the unit for several cycles.
  function automatic logic is_md_op(mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// Bundle between the E stage / hazard unit (master) and the MDU controller (slave).
interface mdu_ctrl_if;
  import mdu_ctrl_pkg::*;

  logic        req;
  logic        start;
  mdu_op_e     op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        rd_hi;
  logic        d_md_use;
  logic [31:0] out;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output req, start, op, rs_val, rt_val, rd_hi, d_md_use,
    input  out, busy, stall, hi, lo
  );

  modport slave (
    input  req, start, op, rs_val, rt_val, rd_hi, d_md_use,
    output out, busy, stall, hi, lo
  );

endinterface

// File: rtl/mdu_ctrl_arith.sv
// Combinational MDU datapath: 64-bit {HI,LO} result for the current operands
// and a flag marking a divide with a zero divisor.
module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  mdu_op_e     op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  output logic [63:0] result_o,
  output logic        div_zero_o
);

  logic signed [63:0] rsWide;
  logic signed [63:0] rtWide;
  logic signed [31:0] rsSigned;
  logic signed [31:0] rtSigned;
  logic signed [31:0] quoSigned;
  logic signed [31:0] remSigned;

  assign rsWide   = {{32{rs_i[31]}}, rs_i};
  assign rtWide   = {{32{rt_i[31]}}, rt_i};
  assign rsSigned = rs_i;
  assign rtSigned = rt_i;

  // Select the product/quotient; the divider is only evaluated with a nonzero
  // divisor, and the INT_MIN / -1 overflow is pinned to a defined value.
  always_comb begin
    result_o   = 64'd0;
    quoSigned  = 32'sd0;
    remSigned  = 32'sd0;
    div_zero_o = (rt_i == 32'd0) && ((op_i == MDU_DIV) || (op_i == MDU_DIVU));
    case (op_i)
      MDU_MULT:  result_o = rsWide * rtWide;
      MDU_MULTU: result_o = {32'd0, rs_i} * {32'd0, rt_i};
      MDU_DIV: begin
        if (rt_i != 32'd0) begin
          if ((rs_i == 32'h8000_0000) && (rt_i == 32'hFFFF_FFFF)) begin
            quoSigned = 32'sh8000_0000;
            remSigned = 32'sd0;
          end else begin
            quoSigned = rsSigned / rtSigned;
            remSigned = rsSigned % rtSigned;
          end
          result_o = {remSigned, quoSigned};
        end
      end
      MDU_DIVU: begin
        if (rt_i != 32'd0) begin
          result_o = {rs_i % rt_i, rs_i / rt_i};
        end
      end
      default: result_o = 64'd0;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU sequencing controller: owns HI/LO, runs the fixed-latency busy countdown
// for mult/div, and raises the D-stage stall for MDU-class instructions.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_LAT = MDU_MULT_LAT,
  parameter int DIV_LAT  = MDU_DIV_LAT
) (
  input logic       clk,
  input logic       reset,
  mdu_ctrl_if.slave bus
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;

  mdu_state_e         state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic [31:0]        hi_q;
  logic [31:0]        lo_q;
  logic [63:0]        pend_q;
  logic               pendValid_q;

  logic               go;
  logic               goMd;
  logic [63:0]        arithResult;
  logic               divZero;

  mdu_arith u_arith (
    .op_i       (bus.op),
    .rs_i       (bus.rs_val),
    .rt_i       (bus.rt_val),
    .result_o   (arithResult),
    .div_zero_o (divZero)
  );

  // A flushed (req) instruction never starts anything; a start while busy is dropped.
  assign go   = bus.start & ~bus.req & (state_q == MDU_IDLE);
  assign goMd = go & is_md_op(bus.op);

  // Controller FSM: launch, count down, and commit the pending result on the last busy cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= MDU_IDLE;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      pend_q      <= 64'd0;
      pendValid_q <= 1'b0;
    end else begin
      case (state_q)
        MDU_IDLE: begin
          if (go) begin
            case (bus.op)
              MDU_MULT, MDU_MULTU: begin
                pend_q      <= arithResult;
                pendValid_q <= 1'b1;
                cnt_q       <= CNT_W'(MULT_LAT - 1);
                busy_q      <= 1'b1;
                state_q     <= MDU_BUSY;
              end
              MDU_DIV, MDU_DIVU: begin
                pend_q      <= arithResult;
                pendValid_q <= ~divZero;
                cnt_q       <= CNT_W'(DIV_LAT - 1);
                busy_q      <= 1'b1;
                state_q     <= MDU_BUSY;
              end
              MDU_MTHI: hi_q <= bus.rs_val;
              MDU_MTLO: lo_q <= bus.rs_val;
              default: ;
            endcase
          end
        end
        MDU_BUSY: begin
          if (cnt_q == '0) begin
            if (pendValid_q) begin
              hi_q <= pend_q[63:32];
              lo_q <= pend_q[31:0];
            end
            pendValid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= MDU_IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= MDU_IDLE;
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.stall = bus.d_md_use & (busy_q | goMd);
  assign bus.out   = bus.rd_hi ? hi_q : lo_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Sequencing controller for the multiply/divide unit in the E stage of the five-stage pipeline.
- Accepts a start from the E-stage instruction and runs a fixed-latency busy countdown; it owns the HI/LO registers.
- Drives the D-stage stall request that holds MDU-class instructions and inserts bubbles into the D/E and E/M pipeline registers.
- Respects exception requests: a start is cancelled when req is asserted in the same cycle.

Parameters:
- MULT_LAT, 5, busy cycles for mult/multu.
- DIV_LAT, 10, busy cycles for div/divu.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- req  input  1  exception/interrupt request from CP0; the E-stage instruction is flushed this cycle.
- start  input  1  E-stage instruction is an MDU operation this cycle.
- op  input  3  MDU opcode (package encodings).
- rs_val  input  32  forwarded rs operand.
- rt_val  input  32  forwarded rt operand.
- rd_hi  input  1  read select for out: 1 = HI, 0 = LO.
- d_md_use  input  1  D-stage instruction is MDU-class (mult/div/mt*/mf*).
- out  output  32  HI or LO per rd_hi, combinational from the registers.
- busy  output  1  an operation is in flight.
- stall  output  1  stall request to the hazard unit.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset: state IDLE, cnt = 0, busy = 0, HI = LO = 0, pending result = 0. Reset mid-operation abandons the result.
- Effective start: go = start & ~req & (state == IDLE). A start while BUSY is ignored; the hazard unit guarantees this never happens.
- States IDLE and BUSY.
- IDLE, go with MULT/MULTU/DIV/DIVU:
  - Latch the 64-bit result into the pending registers.
  - Load cnt = LAT-1 and enter BUSY.
- IDLE, go with MTHI/MTLO: write HI or LO from rs_val at this edge. State stays IDLE and busy stays 0.
- IDLE, go with NONE/MFHI/MFLO: no state change.
- BUSY:
  - busy = 1.
  - cnt decrements each cycle.
  - When cnt == 0, commit pending to HI/LO at that edge and return to IDLE.
  - busy is high for exactly LAT cycles after the go edge.
  - The new HI/LO value is visible on the first cycle busy = 0.
- req during BUSY does not abort. The in-flight instruction is older than the faulting one and has already committed.
- Arithmetic:
  - MULT: signed 32x32 -> 64; HI = [63:32], LO = [31:0].
  - MULTU: same, unsigned.
  - DIV: signed; LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIVU: unsigned divide.
  - Divide by zero (rt_val == 0): do not latch a result; HI/LO stay unchanged. The busy timing is still DIV_LAT.
- stall = d_md_use & (busy | go_md), where go_md = go with a multi-cycle op.
- mfhi/mflo in E read out directly. Correctness is guaranteed by the stall.
- Simultaneous reset and start: reset wins.
- Simultaneous req and start: no effect at all (HI/LO unchanged, busy stays 0).

Decomposition:
- Shared macro package holds:
  - MDU_NONE=0, MDU_MULT=1, MDU_MULTU=2, MDU_DIV=3, MDU_DIVU=4, MDU_MTHI=5, MDU_MTLO=6, MDU_MF=7.
  - Default latency constants.
  - State encodings MDU_IDLE=0, MDU_BUSY=1.
- One sub-module, mdu_arith: combinational 64-bit result and a div-by-zero flag. The controller owns the FSM, counter and HI/LO.

Test Plan:
- MULT rs=0xFFFFFFFD (-3), rt=5:
  - busy high for 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- MULTU with the same operands:
  - HI=0x00000004, LO=0xFFFFFFF1.
  - HI/LO unchanged while busy.
- DIV 7 / -2:
  - After 10 busy cycles, LO=0xFFFFFFFD, HI=0x00000001.
  - DIVU 7/2 gives LO=3, HI=1.
- DIVU rt=0 with HI=0x11, LO=0x22 preset via MTHI/MTLO:
  - busy for 10 cycles.
  - HI/LO remain 0x11/0x22.
- start=1 (MULT) with req=1 in the same cycle:
  - busy stays 0, HI/LO unchanged, stall=0 even with d_md_use=1.
- Stall and mid-op reset:
  - d_md_use=1 during a DIV in flight gives stall=1 every busy cycle, and 0 the cycle after completion.
  - reset at cycle 3 of the DIV gives busy=0, HI=LO=0 next cycle, with no late commit.
